bnn_host_if: RTL and testbench
==============================

BNN_HOST_IF -- requirements
Module: bnn_host_if

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, activation word width; ADDR_W, default 7, activation address width; LANES, default 16, write-enable lanes per word; BETA_W, default 3, beta width; CNT_W, default 16, run-cycle counter width; TIMEOUT, default 65535, watchdog limit in cycles.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports are listed below.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 host_cmd_valid/host_cmd_ready  in/out  1/1  command handshake; transfer occurs when both are high.
REQ-006 host_cmd_op  in  2  command: 0 = READ, 1 = WRITE, 2 = START, 3 = reserved (accepted, no effect).
REQ-007 host_addr  in  ADDR_W, host_wdata  in  DATA_W, host_wmask  in  LANES, host_beta  in  BETA_W  command fields.
REQ-008 host_rsp_valid/host_rsp_data  out  1/DATA_W  read response.
REQ-009 busy, done_pulse, timeout_err  out  1 each; run_cycles  out  CNT_W  length of the last run.
REQ-010 core_start, core_abort  out  1; core_beta  out  BETA_W; core_idle  in  1.
REQ-011 core_addr_rd, core_addr_wr  in  ADDR_W; core_enb_wr  in  LANES  core memory requests.
REQ-012 mem_addr_rd, mem_addr_wr  out  ADDR_W; mem_enb_wr  out  LANES; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  (synchronous read, 1-cycle latency).

Function
REQ-013 FSM states SHALL be IDLE, LAUNCH, WAIT_LO, RUN, FINISH.
REQ-014 host_cmd_ready SHALL be high only in IDLE.
REQ-015 An accepted command SHALL be captured in a one-entry pipeline register and drive the memory port in the following cycle.
REQ-016 Memory mux SHALL select the host pipeline register in IDLE and LAUNCH, and core_* inputs in all other states.
REQ-017 On a WRITE, mem_enb_wr SHALL equal host_wmask. A zero mask SHALL produce no write. All non-WRITE cycles on the host path SHALL drive mem_enb_wr = 0.
REQ-018 On a READ accepted in cycle t, host_rsp_valid SHALL be high for exactly cycle t+2 with host_rsp_data = mem_rdata.
REQ-019 Accepting START SHALL latch host_beta into core_beta, clear timeout_err, clear the run counter, and move to LAUNCH.
REQ-020 LAUNCH SHALL last one cycle, assert core_start for that cycle, and go to WAIT_LO.
REQ-021 WAIT_LO SHALL go to RUN when core_idle is low.
REQ-022 RUN SHALL go to FINISH when core_idle is high.
REQ-023 FINISH SHALL assert done_pulse for one cycle, latch the counter into run_cycles, and return to IDLE.
REQ-024 The counter SHALL increment every cycle in WAIT_LO and RUN, and saturate at 2^CNT_W-1.
REQ-025 If the counter reaches TIMEOUT in WAIT_LO or RUN, the block SHALL assert core_abort for one cycle, set timeout_err (sticky until the next START), latch run_cycles = TIMEOUT, skip done_pulse, and return to IDLE.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 A READ accepted in the cycle before START SHALL still complete its response during LAUNCH/WAIT_LO.

Reset
REQ-028 Reset SHALL force state to IDLE and clear the pipeline register.
REQ-029 During reset, host_cmd_ready=0, host_rsp_valid=0, busy=0, done_pulse=0, timeout_err=0, run_cycles=0, core_start=0, core_abort=0, core_beta=0, mem_enb_wr=0; host_cmd_ready SHALL rise in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-run SHALL discard any in-flight response and SHALL NOT pulse done_pulse or core_abort.

Structure
REQ-031 A shared package bnn_pkg SHALL hold the op enum (READ/WRITE/START/RSVD), the state enum, and the default parameter constants.
REQ-032 The pipeline register plus mux SHALL be one sub-module, bnn_mem_arb. The FSM and counter SHALL stay in bnn_host_if.

Verification
REQ-033 WRITE addr 5, data 16'hA5A5, mask 16'hFFFF, then READ addr 5 -> host_rsp_valid exactly 2 cycles after the READ accept, data 16'hA5A5.
REQ-034 WRITE addr 9, mask 16'h00F0 over existing 16'h0000 with data 16'hFFFF -> read back 16'h00F0 (lane-per-bit memory model); mask 0 -> memory unchanged.
REQ-035 START with beta 3'd5; core_idle low for 40 cycles -> core_start one cycle, core_beta 5, busy high, host_cmd_ready low, one done_pulse, run_cycles 41.
REQ-036 TIMEOUT=20 with core_idle held low -> core_abort pulse, timeout_err=1, run_cycles 20, no done_pulse; the next START clears timeout_err.
REQ-037 READ immediately followed by START -> response still delivered 2 cycles after the READ accept, and core address requests are not muxed until WAIT_LO.
REQ-038 rst asserted in RUN -> all outputs at reset values asynchronously, no done_pulse, host_cmd_ready=1 one cycle after release.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN host interface: command opcodes, FSM states
// and default parameter values.
package bnn_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 7;
    localparam int LANES_DEF   = 16;
    localparam int BETA_W_DEF  = 3;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 65535;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_START = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT_LO = 3'd2,
        RUN     = 3'd3,
        FINISH  = 3'd4
    } state_e;

endpackage

// File: rtl/bnn_mem_arb.sv
// One-entry host command pipeline and the memory-port mux between the host
// pipeline and the core's own memory requests.
module bnn_mem_arb
    import bnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_accept,
    input  op_e               i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [LANES-1:0]  i_wmask,
    input  logic              i_sel_host,
    input  logic [ADDR_W-1:0] i_core_addr_rd,
    input  logic [ADDR_W-1:0] i_core_addr_wr,
    input  logic [LANES-1:0]  i_core_enb_wr,
    output logic [ADDR_W-1:0] o_mem_addr_rd,
    output logic [ADDR_W-1:0] o_mem_addr_wr,
    output logic [LANES-1:0]  o_mem_enb_wr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_rsp_valid
);

    logic              r_pipe_valid;
    op_e               r_pipe_op;
    logic [ADDR_W-1:0] r_pipe_addr;
    logic [DATA_W-1:0] r_pipe_wdata;
    logic [LANES-1:0]  r_pipe_wmask;
    logic              r_rsp_valid;

    // The pipeline holds a command for exactly the cycle after its acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_valid <= 1'b0;
            r_pipe_op    <= OP_READ;
            r_pipe_addr  <= '0;
            r_pipe_wdata <= '0;
            r_pipe_wmask <= '0;
            r_rsp_valid  <= 1'b0;
        end else begin
            r_pipe_valid <= i_accept;
            if (i_accept) begin
                r_pipe_op    <= i_op;
                r_pipe_addr  <= i_addr;
                r_pipe_wdata <= i_wdata;
                r_pipe_wmask <= i_wmask;
            end
            r_rsp_valid <= r_pipe_valid && (r_pipe_op == OP_READ);
        end
    end

    always_comb begin
        o_mem_wdata = r_pipe_wdata;
        if (i_sel_host) begin
            o_mem_addr_rd = r_pipe_addr;
            o_mem_addr_wr = r_pipe_addr;
            o_mem_enb_wr  = (r_pipe_valid && (r_pipe_op == OP_WRITE)) ? r_pipe_wmask : '0;
        end else begin
            o_mem_addr_rd = i_core_addr_rd;
            o_mem_addr_wr = i_core_addr_wr;
            o_mem_enb_wr  = i_core_enb_wr;
        end
    end

    assign o_rsp_valid = r_rsp_valid;

endmodule

// File: rtl/bnn_host_if.sv
// Host command front-end for the BNN core: memory access on behalf of the host,
// run launch/monitoring with a cycle counter and a watchdog abort.
module bnn_host_if
    import bnn_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int BETA_W  = BETA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_cmd_valid,
    output logic              host_cmd_ready,
    input  logic [1:0]        host_cmd_op,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [LANES-1:0]  host_wmask,
    input  logic [BETA_W-1:0] host_beta,
    output logic              host_rsp_valid,
    output logic [DATA_W-1:0] host_rsp_data,
    output logic              busy,
    output logic              done_pulse,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              core_start,
    output logic              core_abort,
    output logic [BETA_W-1:0] core_beta,
    input  logic              core_idle,
    input  logic [ADDR_W-1:0] core_addr_rd,
    input  logic [ADDR_W-1:0] core_addr_wr,
    input  logic [LANES-1:0]  core_enb_wr,
    output logic [ADDR_W-1:0] mem_addr_rd,
    output logic [ADDR_W-1:0] mem_addr_wr,
    output logic [LANES-1:0]  mem_enb_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            r_state;
    logic              r_live;
    logic [CNT_W-1:0]  r_cnt;
    logic [BETA_W-1:0] r_beta;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_run_cycles;
    logic              r_abort;

    logic              w_accept;
    logic              w_sel_host;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_hit_to;

    // r_live keeps the host port closed while reset is held.
    assign host_cmd_ready = r_live && (r_state == IDLE);
    assign w_accept       = host_cmd_valid && host_cmd_ready;
    assign w_sel_host     = (r_state == IDLE) || (r_state == LAUNCH);
    assign w_cnt_inc      = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_hit_to       = 32'(w_cnt_inc) >= 32'(TIMEOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_live        <= 1'b0;
            r_cnt         <= '0;
            r_beta        <= '0;
            r_timeout_err <= 1'b0;
            r_run_cycles  <= '0;
            r_abort       <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && (op_e'(host_cmd_op) == OP_START)) begin
                        r_beta        <= host_beta;
                        r_timeout_err <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= LAUNCH;
                    end
                end
                LAUNCH: r_state <= WAIT_LO;
                WAIT_LO, RUN: begin
                    r_cnt <= w_cnt_inc;
                    // Watchdog takes priority over a completion seen in the same cycle.
                    if (w_hit_to) begin
                        r_abort       <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_run_cycles  <= CNT_W'(TIMEOUT);
                        r_state       <= IDLE;
                    end else if ((r_state == WAIT_LO) && !core_idle) begin
                        r_state <= RUN;
                    end else if ((r_state == RUN) && core_idle) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_run_cycles <= r_cnt;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done_pulse  = (r_state == FINISH);
    assign core_start  = (r_state == LAUNCH);
    assign core_abort  = r_abort;
    assign core_beta   = r_beta;
    assign timeout_err = r_timeout_err;
    assign run_cycles  = r_run_cycles;
    assign host_rsp_data = mem_rdata;

    bnn_mem_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_arb (
        .i_clk          (clk),
        .i_rst_n        (rst),
        .i_accept       (w_accept),
        .i_op           (op_e'(host_cmd_op)),
        .i_addr         (host_addr),
        .i_wdata        (host_wdata),
        .i_wmask        (host_wmask),
        .i_sel_host     (w_sel_host),
        .i_core_addr_rd (core_addr_rd),
        .i_core_addr_wr (core_addr_wr),
        .i_core_enb_wr  (core_enb_wr),
        .o_mem_addr_rd  (mem_addr_rd),
        .o_mem_addr_wr  (mem_addr_wr),
        .o_mem_enb_wr   (mem_enb_wr),
        .o_mem_wdata    (mem_wdata),
        .o_rsp_valid    (host_rsp_valid)
    );

endmodule

// File: tb/tb_bnn_host_if.sv
// Directed bench for bnn_host_if: a default-parameter instance with a lane-per-bit
// memory model, plus a TIMEOUT=20 instance for the watchdog path.
module tb_bnn_host_if;
    import bnn_pkg::*;

    logic        clk;
    logic        rst;
    logic        host_cmd_valid;
    logic [1:0]  host_cmd_op;
    logic [6:0]  host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_wmask;
    logic [2:0]  host_beta;
    logic        core_idle;
    logic [6:0]  core_addr_rd;
    logic [6:0]  core_addr_wr;
    logic [15:0] core_enb_wr;

    logic        host_cmd_ready, host_rsp_valid, busy, done_pulse, timeout_err;
    logic        core_start, core_abort;
    logic [15:0] host_rsp_data, run_cycles, mem_enb_wr, mem_wdata, mem_rdata;
    logic [2:0]  core_beta;
    logic [6:0]  mem_addr_rd, mem_addr_wr;

    logic        t_host_cmd_ready, t_host_rsp_valid, t_busy, t_done_pulse, t_timeout_err;
    logic        t_core_start, t_core_abort;
    logic [15:0] t_host_rsp_data, t_run_cycles, t_mem_enb_wr, t_mem_wdata;
    logic [2:0]  t_core_beta;
    logic [6:0]  t_mem_addr_rd, t_mem_addr_wr;
    logic [15:0] tMemRdata;

    logic [15:0] memArray [0:127];

    int compareCount = 0;
    int mismatchCount = 0;
    int doneCount = 0;
    int startCount = 0;
    int abortCount = 0;
    int tDoneCount = 0;
    int tAbortCount = 0;

    bnn_host_if dut (
        .clk(clk), .rst(rst),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_wmask(host_wmask), .host_beta(host_beta),
        .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
        .busy(busy), .done_pulse(done_pulse), .timeout_err(timeout_err), .run_cycles(run_cycles),
        .core_start(core_start), .core_abort(core_abort), .core_beta(core_beta), .core_idle(core_idle),
        .core_addr_rd(core_addr_rd), .core_addr_wr(core_addr_wr), .core_enb_wr(core_enb_wr),
        .mem_addr_rd(mem_addr_rd), .mem_addr_wr(mem_addr_wr), .mem_enb_wr(mem_enb_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    bnn_host_if #(.TIMEOUT(20)) dutTo (
        .clk(clk), .rst(rst),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(t_host_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_wmask(host_wmask), .host_beta(host_beta),
        .host_rsp_valid(t_host_rsp_valid), .host_rsp_data(t_host_rsp_data),
        .busy(t_busy), .done_pulse(t_done_pulse), .timeout_err(t_timeout_err), .run_cycles(t_run_cycles),
        .core_start(t_core_start), .core_abort(t_core_abort), .core_beta(t_core_beta), .core_idle(core_idle),
        .core_addr_rd(core_addr_rd), .core_addr_wr(core_addr_wr), .core_enb_wr(core_enb_wr),
        .mem_addr_rd(t_mem_addr_rd), .mem_addr_wr(t_mem_addr_wr), .mem_enb_wr(t_mem_enb_wr),
        .mem_wdata(t_mem_wdata), .mem_rdata(tMemRdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int a = 0; a < 128; a++) memArray[a] = 16'h0000;
        mem_rdata = 16'h0000;
        tMemRdata = 16'h0000;
    end

    // Synchronous-read memory with one write-enable lane per data bit.
    always @(posedge clk) begin
        for (int b = 0; b < 16; b++) begin
            if (mem_enb_wr[b]) memArray[mem_addr_wr][b] <= mem_wdata[b];
        end
        mem_rdata <= memArray[mem_addr_rd];
    end

    always @(negedge clk) begin
        if (done_pulse)   doneCount++;
        if (core_start)   startCount++;
        if (core_abort)   abortCount++;
        if (t_done_pulse) tDoneCount++;
        if (t_core_abort) tAbortCount++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion by 100000ns, expected completion");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string p);
        checkOutput({p, ".ready"},     32'(host_cmd_ready), 0);
        checkOutput({p, ".rspValid"},  32'(host_rsp_valid), 0);
        checkOutput({p, ".busy"},      32'(busy), 0);
        checkOutput({p, ".done"},      32'(done_pulse), 0);
        checkOutput({p, ".timeout"},   32'(timeout_err), 0);
        checkOutput({p, ".runCycles"}, 32'(run_cycles), 0);
        checkOutput({p, ".coreStart"}, 32'(core_start), 0);
        checkOutput({p, ".coreAbort"}, 32'(core_abort), 0);
        checkOutput({p, ".coreBeta"},  32'(core_beta), 0);
        checkOutput({p, ".memEnb"},    32'(mem_enb_wr), 0);
    endtask

    // Returns #1 after the accepting edge, i.e. early in cycle t+1.
    task automatic applyStimulus(input logic [1:0] op, input logic [6:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] mask, input logic [2:0] beta);
        int waitCycles;
        waitCycles = 0;
        @(negedge clk);
        host_cmd_valid = 1'b1;
        host_cmd_op    = op;
        host_addr      = addr;
        host_wdata     = wdata;
        host_wmask     = mask;
        host_beta      = beta;
        while (!host_cmd_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("cmdReady", 32'(host_cmd_ready), 1);
        @(posedge clk);
        #1;
        host_cmd_valid = 1'b0;
    endtask

    task automatic checkReadResponse(input string tag, input logic [15:0] expData);
        @(negedge clk);
        checkOutput({tag, ".validT1"}, 32'(host_rsp_valid), 0);
        checkOutput({tag, ".enbT1"},   32'(mem_enb_wr), 0);
        @(negedge clk);
        checkOutput({tag, ".validT2"}, 32'(host_rsp_valid), 1);
        checkOutput({tag, ".dataT2"},  32'(host_rsp_data), 32'(expData));
        @(negedge clk);
        checkOutput({tag, ".validT3"}, 32'(host_rsp_valid), 0);
    endtask

    initial begin
        int waitCycles;
        int snapDone, snapStart, snapAbort;
        rst = 1'b0;
        host_cmd_valid = 1'b0;
        host_cmd_op = 2'd0;
        host_addr = 7'd0;
        host_wdata = 16'h0;
        host_wmask = 16'h0;
        host_beta = 3'd0;
        core_idle = 1'b1;
        core_addr_rd = 7'h33;
        core_addr_wr = 7'h44;
        core_enb_wr = 16'h0;

        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b1;
        #1 checkOutput("readyAtRelease", 32'(host_cmd_ready), 0);
        @(negedge clk);
        checkOutput("readyAfterRelease", 32'(host_cmd_ready), 1);

        // Full-mask write then read-back.
        applyStimulus(OP_WRITE, 7'd5, 16'hA5A5, 16'hFFFF, 3'd0);
        @(negedge clk);
        checkOutput("wr5.enb",  32'(mem_enb_wr), 32'hFFFF);
        checkOutput("wr5.addr", 32'(mem_addr_wr), 5);
        checkOutput("wr5.data", 32'(mem_wdata), 32'hA5A5);
        applyStimulus(OP_READ, 7'd5, 16'h0, 16'h0, 3'd0);
        checkReadResponse("rd5", 16'hA5A5);

        // Partial, zero and reserved-op writes to address 9.
        applyStimulus(OP_WRITE, 7'd9, 16'hFFFF, 16'h00F0, 3'd0);
        applyStimulus(OP_READ, 7'd9, 16'h0, 16'h0, 3'd0);
        checkReadResponse("rd9a", 16'h00F0);
        applyStimulus(OP_WRITE, 7'd9, 16'h1234, 16'h0000, 3'd0);
        @(negedge clk);
        checkOutput("wrZero.enb", 32'(mem_enb_wr), 0);
        applyStimulus(OP_READ, 7'd9, 16'h0, 16'h0, 3'd0);
        checkReadResponse("rd9b", 16'h00F0);
        applyStimulus(OP_WRITE, 7'd9, 16'h1234, 16'hFF00, 3'd0);
        applyStimulus(OP_RSVD, 7'd9, 16'hFFFF, 16'hFFFF, 3'd7);
        @(negedge clk);
        checkOutput("rsvd.enb",  32'(mem_enb_wr), 0);
        checkOutput("rsvd.busy", 32'(busy), 0);
        checkOutput("rsvd.beta", 32'(core_beta), 0);
        applyStimulus(OP_READ, 7'd9, 16'h0, 16'h0, 3'd0);
        checkReadResponse("rd9c", 16'h12F0);

        // READ immediately followed by START, then a 41-cycle run.
        snapDone = doneCount;
        snapStart = startCount;
        applyStimulus(OP_READ, 7'd5, 16'h0, 16'h0, 3'd0);
        applyStimulus(OP_START, 7'h11, 16'h0, 16'hFFFF, 3'd5);
        @(negedge clk);
        checkOutput("launch.rspValid", 32'(host_rsp_valid), 1);
        checkOutput("launch.rspData",  32'(host_rsp_data), 32'hA5A5);
        checkOutput("launch.start",    32'(core_start), 1);
        checkOutput("launch.busy",     32'(busy), 1);
        checkOutput("launch.ready",    32'(host_cmd_ready), 0);
        checkOutput("launch.beta",     32'(core_beta), 5);
        checkOutput("launch.addrRd",   32'(mem_addr_rd), 32'h11);
        checkOutput("launch.enb",      32'(mem_enb_wr), 0);
        @(negedge clk);
        checkOutput("waitLo.rspValid", 32'(host_rsp_valid), 0);
        checkOutput("waitLo.start",    32'(core_start), 0);
        checkOutput("waitLo.addrRd",   32'(mem_addr_rd), 32'h33);
        core_idle = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) begin
                checkOutput("run.addrWr", 32'(mem_addr_wr), 32'h44);
                checkOutput("run.busy",   32'(busy), 1);
                checkOutput("run.ready",  32'(host_cmd_ready), 0);
                checkOutput("run.done",   32'(done_pulse), 0);
            end
        end
        core_idle = 1'b1;
        @(negedge clk);
        checkOutput("finish.done", 32'(done_pulse), 1);
        @(negedge clk);
        checkOutput("finish.doneOff",   32'(done_pulse), 0);
        checkOutput("finish.runCycles", 32'(run_cycles), 41);
        checkOutput("finish.busy",      32'(busy), 0);
        checkOutput("finish.ready",     32'(host_cmd_ready), 1);
        checkOutput("finish.doneCount", 32'(doneCount - snapDone), 1);
        checkOutput("finish.startCount", 32'(startCount - snapStart), 1);

        // Watchdog on the TIMEOUT=20 instance.
        snapDone = tDoneCount;
        snapAbort = tAbortCount;
        applyStimulus(OP_START, 7'd0, 16'h0, 16'h0, 3'd2);
        @(negedge clk);
        checkOutput("to.launchTerr", 32'(t_timeout_err), 0);
        core_idle = 1'b0;
        waitCycles = 0;
        while (!t_core_abort && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("to.abortLatency", 32'(waitCycles), 21);
        checkOutput("to.terr",      32'(t_timeout_err), 1);
        checkOutput("to.runCycles", 32'(t_run_cycles), 20);
        checkOutput("to.busy",      32'(t_busy), 0);
        @(negedge clk);
        checkOutput("to.abortOff",   32'(t_core_abort), 0);
        checkOutput("to.terrSticky", 32'(t_timeout_err), 1);
        checkOutput("to.doneCount",  32'(tDoneCount - snapDone), 0);
        checkOutput("to.abortCount", 32'(tAbortCount - snapAbort), 1);
        core_idle = 1'b1;
        applyStimulus(OP_START, 7'd0, 16'h0, 16'h0, 3'd6);
        @(negedge clk);
        checkOutput("to.restartTerr", 32'(t_timeout_err), 0);
        checkOutput("to.restartBeta", 32'(t_core_beta), 6);
        checkOutput("to.keptRun",     32'(t_run_cycles), 20);
        core_idle = 1'b0;
        repeat (2) @(negedge clk);
        core_idle = 1'b1;

        // Asynchronous reset in RUN.
        applyStimulus(OP_START, 7'd0, 16'h0, 16'h0, 3'd3);
        @(negedge clk);
        core_idle = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rr.busyBefore", 32'(busy), 1);
        snapDone = doneCount;
        snapAbort = abortCount;
        #2 rst = 1'b0;
        #1 checkIdleOutputs("asyncRst");
        core_idle = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("rr.readyAtRelease", 32'(host_cmd_ready), 0);
        @(negedge clk);
        checkOutput("rr.readyAfter", 32'(host_cmd_ready), 1);
        checkOutput("rr.noDone",  32'(doneCount - snapDone), 0);
        checkOutput("rr.noAbort", 32'(abortCount - snapAbort), 0);

        // Reset between READ accept and its response discards the response.
        applyStimulus(OP_READ, 7'd5, 16'h0, 16'h0, 3'd0);
        #2 rst = 1'b0;
        #1 checkOutput("rdRst.validInRst", 32'(host_rsp_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rdRst.noRsp", 32'(host_rsp_valid), 0);
        applyStimulus(OP_READ, 7'd9, 16'h0, 16'h0, 3'd0);
        checkReadResponse("rdAfterRst", 16'h12F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
